// File: rtl/dmem_responder_if.sv
// Request/response bus between the core's load/store path and the data memory.
//
// Handshake rules: a request transfers on a rising edge where req_valid and
// req_ready are both 1; the requester holds req_we/req_addr/req_wd stable until
// then. A response transfers on a rising edge where resp_valid and resp_ready
// are both 1; the responder holds resp_rd/resp_err stable until then.
interface dmem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wd;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rd;
    logic        resp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wd, resp_ready,
        input  req_ready, resp_valid, resp_rd, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wd, resp_ready,
        output req_ready, resp_valid, resp_rd, resp_err
    );
endinterface

// File: rtl/dmem_responder.sv
// Word-organised data RAM behind a valid/ready handshake with a fixed number
// of wait states, address checking and debug transaction/error counters.
module dmem_responder #(
    parameter int ADDR_BITS   = 10,
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clock,
    input  logic              reset,
    dmem_responder_if.slave   bus,
    output logic [15:0]       txn_count,
    output logic [7:0]        err_count,
    output logic [1:0]        state_dbg
);

    localparam int         IDX_BITS  = ADDR_BITS - 2;
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_ACCESS = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [3:0]            wait_cnt;
    logic                  lat_we;
    logic                  lat_err;
    logic [31:0]           lat_wd;
    logic [IDX_BITS-1:0]   lat_idx;
    logic [31:0]           mem [DEPTH];

    logic accept;
    logic addr_err;

    assign accept   = bus.req_valid && bus.req_ready;
    assign addr_err = (bus.req_addr[1:0] != 2'b00) || (bus.req_addr[31:ADDR_BITS] != '0);

    // State register.
    always_ff @(posedge clock) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    // Next-state logic: IDLE -> [WAIT] -> ACCESS -> RESP -> IDLE.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:   if (accept) state_next = (WAIT_CYCLES == 0) ? S_ACCESS : S_WAIT;
            S_WAIT:   if (wait_cnt <= 4'd1) state_next = S_ACCESS;
            S_ACCESS: state_next = S_RESP;
            S_RESP:   if (bus.resp_ready) state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    // Handshake outputs decoded from the state alone.
    always_comb begin
        bus.req_ready  = (state == S_IDLE);
        bus.resp_valid = (state == S_RESP);
        state_dbg      = state;
    end

    // Request latch, wait counter, response registers and debug counters.
    always_ff @(posedge clock) begin
        if (reset) begin
            wait_cnt     <= 4'd0;
            lat_we       <= 1'b0;
            lat_err      <= 1'b0;
            lat_wd       <= 32'd0;
            lat_idx      <= '0;
            bus.resp_rd  <= 32'd0;
            bus.resp_err <= 1'b0;
            txn_count    <= 16'd0;
            err_count    <= 8'd0;
        end else begin
            if (accept) begin
                lat_we    <= bus.req_we;
                lat_wd    <= bus.req_wd;
                lat_idx   <= bus.req_addr[ADDR_BITS-1:2];
                lat_err   <= addr_err;
                wait_cnt  <= WAIT_INIT;
                txn_count <= txn_count + 16'd1;
                if (addr_err && (err_count != 8'hFF)) err_count <= err_count + 8'd1;
            end
            if (state == S_WAIT) wait_cnt <= wait_cnt - 4'd1;
            if (state == S_ACCESS) begin
                bus.resp_err <= lat_err;
                bus.resp_rd  <= (!lat_we && !lat_err) ? mem[lat_idx] : 32'd0;
            end
        end
    end

    // RAM write port; contents survive reset, but a write coinciding with reset is dropped.
    always_ff @(posedge clock) begin
        if (!reset && (state == S_ACCESS) && lat_we && !lat_err) mem[lat_idx] <= lat_wd;
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one instance with two wait states and one
// with none, sharing clock and reset.
module tb_dmem_responder;

    logic clock;
    logic reset;

    int checks = 0;
    int errors = 0;

    // Index 0 drives the WAIT_CYCLES=2 instance, index 1 the WAIT_CYCLES=0 one.
    logic        req_valid  [2];
    logic        req_we     [2];
    logic [31:0] req_addr   [2];
    logic [31:0] req_wd     [2];
    logic        resp_ready [2];
    logic        rdy        [2];
    logic        rv         [2];
    logic [31:0] rrd        [2];
    logic        rerr       [2];
    logic [15:0] txn        [2];
    logic [7:0]  errc       [2];
    logic [1:0]  st         [2];

    dmem_responder_if bus2 ();
    dmem_responder_if bus0 ();

    assign bus2.req_valid  = req_valid[0];
    assign bus2.req_we     = req_we[0];
    assign bus2.req_addr   = req_addr[0];
    assign bus2.req_wd     = req_wd[0];
    assign bus2.resp_ready = resp_ready[0];
    assign rdy[0]          = bus2.req_ready;
    assign rv[0]           = bus2.resp_valid;
    assign rrd[0]          = bus2.resp_rd;
    assign rerr[0]         = bus2.resp_err;

    assign bus0.req_valid  = req_valid[1];
    assign bus0.req_we     = req_we[1];
    assign bus0.req_addr   = req_addr[1];
    assign bus0.req_wd     = req_wd[1];
    assign bus0.resp_ready = resp_ready[1];
    assign rdy[1]          = bus0.req_ready;
    assign rv[1]           = bus0.resp_valid;
    assign rrd[1]          = bus0.resp_rd;
    assign rerr[1]         = bus0.resp_err;

    dmem_responder #(.ADDR_BITS(10), .DEPTH(256), .WAIT_CYCLES(2)) u_dut2 (
        .clock     (clock),
        .reset     (reset),
        .bus       (bus2),
        .txn_count (txn[0]),
        .err_count (errc[0]),
        .state_dbg (st[0])
    );

    dmem_responder #(.ADDR_BITS(10), .DEPTH(256), .WAIT_CYCLES(0)) u_dut0 (
        .clock     (clock),
        .reset     (reset),
        .bus       (bus0),
        .txn_count (txn[1]),
        .err_count (errc[1]),
        .state_dbg (st[1])
    );

    // Clock and reset.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Present a request and return just after the edge that accepts it.
    task automatic send(input int d, input logic we, input logic [31:0] addr, input logic [31:0] wd);
        int n;
        req_we[d]    = we;
        req_addr[d]  = addr;
        req_wd[d]    = wd;
        req_valid[d] = 1'b1;
        n = 0;
        while (!rdy[d] && n < 50) begin
            tick();
            n++;
        end
        if (!rdy[d]) check("accept_timeout", 32'(rdy[d]), 32'd1);
        tick();
        req_valid[d] = 1'b0;
    endtask

    // Full transaction with resp_ready held high; lat counts edges from accept to resp_valid.
    task automatic txn_do(input int d, input logic we, input logic [31:0] addr, input logic [31:0] wd,
                          output int lat, output logic [31:0] rd, output logic err);
        send(d, we, addr, wd);
        lat = 0;
        while (!rv[d] && lat < 50) begin
            tick();
            lat++;
        end
        if (!rv[d]) check("resp_timeout", 32'(rv[d]), 32'd1);
        rd  = rrd[d];
        err = rerr[d];
        tick();
    endtask

    // Directed sequence.
    initial begin
        int          lat;
        logic [31:0] rd;
        logic        err;

        for (int i = 0; i < 2; i++) begin
            req_valid[i]  = 1'b0;
            req_we[i]     = 1'b0;
            req_addr[i]   = 32'd0;
            req_wd[i]     = 32'd0;
            resp_ready[i] = 1'b1;
        end
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;

        check("rst_req_ready",  32'(rdy[0]),  32'd1);
        check("rst_resp_valid", 32'(rv[0]),   32'd0);
        check("rst_resp_rd",    rrd[0],       32'd0);
        check("rst_resp_err",   32'(rerr[0]), 32'd0);
        check("rst_txn",        32'(txn[0]),  32'd0);
        check("rst_err",        32'(errc[0]), 32'd0);
        check("rst_state",      32'(st[0]),   32'd0);

        // Aligned store then load.
        txn_do(0, 1'b1, 32'h0000_0040, 32'hDEAD_BEEF, lat, rd, err);
        check("st40_lat", 32'(lat), 32'd3);
        check("st40_err", 32'(err), 32'd0);
        check("st40_rd",  rd,       32'd0);
        check("st40_idle_ready", 32'(rdy[0]), 32'd1);
        txn_do(0, 1'b0, 32'h0000_0040, 32'd0, lat, rd, err);
        check("ld40_rd",  rd,       32'hDEAD_BEEF);
        check("ld40_err", 32'(err), 32'd0);
        check("ld40_txn", 32'(txn[0]), 32'd2);

        // Misaligned store leaves RAM alone.
        txn_do(0, 1'b1, 32'h0000_0042, 32'h1234_5678, lat, rd, err);
        check("st42_err", 32'(err), 32'd1);
        check("st42_rd",  rd,       32'd0);
        txn_do(0, 1'b0, 32'h0000_0040, 32'd0, lat, rd, err);
        check("ld40b_rd", rd, 32'hDEAD_BEEF);
        check("st42_errcnt", 32'(errc[0]), 32'd1);

        // Out-of-range load.
        txn_do(0, 1'b0, 32'h0000_0400, 32'd0, lat, rd, err);
        check("ld400_err", 32'(err), 32'd1);
        check("ld400_rd",  rd,       32'd0);
        txn_do(0, 1'b0, 32'h0000_0040, 32'd0, lat, rd, err);
        check("ld40c_rd",  rd, 32'hDEAD_BEEF);
        check("ld400_errcnt", 32'(errc[0]), 32'd2);
        check("ld400_txn", 32'(txn[0]), 32'd6);

        // Backpressure: response held while a competing store is offered.
        resp_ready[0] = 1'b0;
        send(0, 1'b0, 32'h0000_0040, 32'd0);
        check("bp_state_wait", 32'(st[0]), 32'd1);
        repeat (3) tick();
        req_we[0]    = 1'b1;
        req_addr[0]  = 32'h0000_0040;
        req_wd[0]    = 32'hBAD0_BAD0;
        req_valid[0] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("bp_resp_valid", 32'(rv[0]),  32'd1);
            check("bp_resp_rd",    rrd[0],      32'hDEAD_BEEF);
            check("bp_req_ready",  32'(rdy[0]), 32'd0);
            tick();
        end
        req_valid[0]  = 1'b0;
        resp_ready[0] = 1'b1;
        tick();
        check("bp_release_ready", 32'(rdy[0]), 32'd1);
        check("bp_release_valid", 32'(rv[0]),  32'd0);
        check("bp_txn", 32'(txn[0]), 32'd7);
        txn_do(0, 1'b0, 32'h0000_0040, 32'd0, lat, rd, err);
        check("bp_ram_intact", rd, 32'hDEAD_BEEF);

        // Reset during WAIT abandons the store.
        txn_do(0, 1'b1, 32'h0000_0080, 32'h1111_2222, lat, rd, err);
        send(0, 1'b1, 32'h0000_0080, 32'h55AA_55AA);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_rst_state", 32'(st[0]),   32'd0);
        check("mid_rst_ready", 32'(rdy[0]),  32'd1);
        check("mid_rst_valid", 32'(rv[0]),   32'd0);
        check("mid_rst_rd",    rrd[0],       32'd0);
        check("mid_rst_err",   32'(rerr[0]), 32'd0);
        check("mid_rst_txn",   32'(txn[0]),  32'd0);
        check("mid_rst_errc",  32'(errc[0]), 32'd0);
        txn_do(0, 1'b0, 32'h0000_0080, 32'd0, lat, rd, err);
        check("wait_rst_ld80", rd, 32'h1111_2222);
        check("wait_rst_txn", 32'(txn[0]), 32'd1);

        // Reset coinciding with the ACCESS edge also drops the store.
        send(0, 1'b1, 32'h0000_0080, 32'h55AA_55AA);
        tick();
        tick();
        check("acc_state", 32'(st[0]), 32'd2);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        txn_do(0, 1'b0, 32'h0000_0080, 32'd0, lat, rd, err);
        check("acc_rst_ld80", rd, 32'h1111_2222);

        // Zero-wait instance: single-edge latency and the idle bubble.
        txn_do(1, 1'b1, 32'h0000_0000, 32'hA0A0_A0A0, lat, rd, err);
        check("w0_st0_lat", 32'(lat), 32'd1);
        txn_do(1, 1'b1, 32'h0000_0004, 32'hB1B1_B1B1, lat, rd, err);
        req_we[1]    = 1'b0;
        req_addr[1]  = 32'h0000_0000;
        req_valid[1] = 1'b1;
        check("w0_ready0", 32'(rdy[1]), 32'd1);
        tick();
        req_addr[1] = 32'h0000_0004;
        check("w0_access_state", 32'(st[1]), 32'd2);
        check("w0_busy_ready",   32'(rdy[1]), 32'd0);
        tick();
        check("w0_ld0_valid", 32'(rv[1]), 32'd1);
        check("w0_ld0_rd",    rrd[1],     32'hA0A0_A0A0);
        tick();
        check("w0_bubble_ready", 32'(rdy[1]), 32'd1);
        check("w0_bubble_valid", 32'(rv[1]),  32'd0);
        tick();
        req_valid[1] = 1'b0;
        check("w0_ld4_pending", 32'(rv[1]), 32'd0);
        tick();
        check("w0_ld4_valid", 32'(rv[1]), 32'd1);
        check("w0_ld4_rd",    rrd[1],     32'hB1B1_B1B1);
        tick();

        // Error counter saturation.
        for (int i = 0; i < 300; i++) begin
            txn_do(1, 1'b0, (i % 2 == 0) ? 32'h0000_0003 : 32'h0001_0000, 32'd0, lat, rd, err);
        end
        check("sat_last_err", 32'(err), 32'd1);
        check("sat_last_rd",  rd,       32'd0);
        check("sat_errcnt",   32'(errc[1]), 32'd255);
        check("sat_txn",      32'(txn[1]),  32'd304);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
Memory-side responder for the processor's data port: a word-organised data RAM behind a valid/ready request/response handshake, with a programmable wait-state count.
- Lets the core's load/store path run against slow memory. It replaces the always-ready single-cycle data memory when the multi-cycle core is built.
- Validates each address for alignment and range, and reports bad accesses through a response error flag.
- Keeps an accepted-transaction counter and an error counter for debug display.

Parameters:
- ADDR_BITS, 10, number of low byte-address bits decoded. Memory spans 2^ADDR_BITS bytes.
- DEPTH, 256, number of 32-bit words. Must equal 2^(ADDR_BITS-2).
- WAIT_CYCLES, 2, wait-state cycles inserted before the array access. Legal range is 0..15.

Ports:
- clock, input, 1, single clock; all state updates on the rising edge.
- reset, input, 1, synchronous, active-high.
- req_valid, input, 1, requester presents a transaction.
- req_ready, output, 1, responder can accept a request this cycle.
- req_we, input, 1, 1 = store word, 0 = load word.
- req_addr, input, 32, byte address (from the ALU result).
- req_wd, input, 32, store data.
- resp_valid, output, 1, response available.
- resp_ready, input, 1, requester consumes the response.
- resp_rd, output, 32, load data; 0 for stores and errored accesses.
- resp_err, output, 1, access was misaligned or out of range.
- txn_count, output, 16, accepted transactions; wraps.
- err_count, output, 8, errored transactions; saturates at 255.

Behaviour:
- Reset values: state IDLE, req_ready=1, resp_valid=0, resp_rd=0, resp_err=0, txn_count=0, err_count=0, wait counter=0.
- RAM contents are not cleared by reset.
- Accept: a request is accepted on an edge where req_valid=1 and req_ready=1. On acceptance the block latches:
  - req_we and req_wd;
  - word index = req_addr[ADDR_BITS-1:2];
  - err = (req_addr[1:0] != 0) or (req_addr[31:ADDR_BITS] != 0).
- Also on acceptance: txn_count increments; err_count increments if err and below 255.
- FSM states: IDLE, WAIT, ACCESS, RESP.
- IDLE: req_ready=1, resp_valid=0.
  - On accept: go to WAIT with counter=WAIT_CYCLES, or go directly to ACCESS if WAIT_CYCLES=0.
- WAIT: req_ready=0.
  - Counter decrements every cycle; exits to ACCESS on the edge where the counter is 1.
  - Net effect: exactly WAIT_CYCLES cycles are spent in WAIT.
- ACCESS: exactly one cycle, req_ready=0.
  - Store with no error: writes the word at this edge.
  - Load with no error: registers RAM[index] into resp_rd.
  - Store or error: resp_rd is loaded with 0.
  - resp_err is loaded from the latched err. Next state is RESP.
- RESP: resp_valid=1, req_ready=0.
  - resp_rd and resp_err are held stable until the edge where resp_ready=1; that edge returns the FSM to IDLE.
- Latency: resp_valid is first seen high WAIT_CYCLES+1 edges after the accept edge.
  - Example: WAIT_CYCLES=2, accept at edge e0, resp_valid high after e3.
- Throughput: at least one IDLE cycle between a response handshake and the next accept. Maximum one transaction per WAIT_CYCLES+3 cycles.
- Input changes while busy: req_valid, req_addr, req_we and req_wd are ignored outside IDLE. The requester must hold the request until it is accepted.
- resp_ready is ignored outside RESP; an early resp_ready has no effect.
- Errored store: RAM is not modified, resp_err=1, resp_rd=0.
- Errored load: resp_rd=0, resp_err=1.
- Reset mid-operation (WAIT, ACCESS or RESP): next state IDLE and all outputs return to reset values.
  - A store whose ACCESS edge coincides with reset is not performed.
  - A store completed before reset is retained.
- Counter boundaries: txn_count wraps 65535→0. err_count holds at 255.

Test Plan:
- WAIT_CYCLES=2. After reset, store 0xDEADBEEF to 0x00000040 with resp_ready held 1 → resp_valid high after edge e3, resp_err=0, resp_rd=0. Then load 0x40 → resp_rd=0xDEADBEEF, txn_count=2.
- Misaligned store of 0x12345678 to 0x42, then load 0x40 → first response has resp_err=1; load returns 0xDEADBEEF; err_count=1.
- Out-of-range load from 0x00000400 → resp_err=1, resp_rd=0, RAM unchanged.
- Backpressure: load 0x40 with resp_ready=0 for 5 cycles → resp_valid and resp_rd stay stable, req_ready=0. A new req_valid during this window is not accepted. Raising resp_ready → IDLE next cycle, req_ready=1.
- Reset mid-operation: store 0x55AA55AA to 0x80, assert reset during WAIT, then load 0x80 → old contents of 0x80 returned. Outputs are at reset values one edge after reset.
- WAIT_CYCLES=0 build: back-to-back loads of 0x0 and 0x4 → each response 1 edge after accept, one idle bubble between them. 300 errored accesses → err_count=255.
